// File: rtl/shift_issue_pkg.sv
// Purpose: shared constants and stage payload types for the shift issue unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package shift_issue_pkg;

  localparam int DW = 32;  // operand / result width
  localparam int AW = 5;   // register address and shift amount width

  // Shiftop encodings understood by the external shifter
  localparam logic [1:0] SHIFTOP_LEFT      = 2'b00;
  localparam logic [1:0] SHIFTOP_RIGHT_LOG = 2'b10;
  localparam logic [1:0] SHIFTOP_RIGHT_ART = 2'b11;

  localparam logic [5:0] OPCODE_SPECIAL = 6'b000000;

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV = 6'b000111;

  // Stage 1 payload: drives the shifter operands directly
  typedef struct packed {
    logic [DW-1:0] a;
    logic [AW-1:0] b;
    logic [1:0]    op;
    logic [AW-1:0] waddr;
    logic          illegal;
  } s1_t;

  // Stage 2 payload: drives the writeback outputs directly
  typedef struct packed {
    logic [DW-1:0] result;
    logic [AW-1:0] waddr;
    logic          illegal;
  } s2_t;

endpackage

// File: rtl/shift_issue_decode.sv
// Purpose: combinational decode of MIPS R-type shifts into shiftop, amount, waddr, illegal.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluated every cycle regardless of handshake state.
// Ports: inst/rs_data in; op, amount, waddr, illegal out.
module shift_decode
  import shift_issue_pkg::*;
(
  input  logic [31:0]   inst,
  input  logic [DW-1:0] rs_data,
  output logic [1:0]    op,
  output logic [AW-1:0] amount,
  output logic [AW-1:0] waddr,
  output logic          illegal
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = inst[31:26];
  assign funct  = inst[5:0];
  assign waddr  = inst[15:11];

  // rs/rt register numbers are resolved upstream; only rs_data[4:0] is an amount
  logic unused_bits;
  assign unused_bits = ^{inst[25:16], rs_data[DW-1:AW]};

  always_comb begin
    op      = SHIFTOP_LEFT;
    amount  = inst[10:6];
    illegal = 1'b0;
    if (opcode != OPCODE_SPECIAL) begin
      illegal = 1'b1;
    end else begin
      case (funct)
        FUNCT_SLL:  op = SHIFTOP_LEFT;
        FUNCT_SRL:  op = SHIFTOP_RIGHT_LOG;
        FUNCT_SRA:  op = SHIFTOP_RIGHT_ART;
        FUNCT_SLLV: begin op = SHIFTOP_LEFT;      amount = rs_data[AW-1:0]; end
        FUNCT_SRLV: begin op = SHIFTOP_RIGHT_LOG; amount = rs_data[AW-1:0]; end
        FUNCT_SRAV: begin op = SHIFTOP_RIGHT_ART; amount = rs_data[AW-1:0]; end
        default:    illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/shift_issue.sv
// Purpose: two-stage issue unit feeding an external combinational shifter and capturing its result.
// Latency: accept at edge N gives out_valid after edge N+1 (two registers, no input-to-output bypass).
// Backpressure: valid/ready both sides; out_ready ripples combinationally to in_ready; two entries buffered.
// Ports: clk, rst_n (async active-low), flush; in_* upstream handshake; sh_* to/from shifter; out_* writeback.
// Option: define SHIFT_ISSUE_ILLEGAL_EN to pass non-shift instructions through with out_illegal=1,
//         otherwise they are accepted and dropped and out_illegal is absent.
module shift_issue
  import shift_issue_pkg::*;
#(
  parameter int DATA_WIDTH = 32  // only 32 is supported
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst,
  input  logic [DATA_WIDTH-1:0] in_rs_data,
  input  logic [DATA_WIDTH-1:0] in_rt_data,
  output logic [DATA_WIDTH-1:0] sh_A,
  output logic [4:0]            sh_B,
  output logic [1:0]            sh_Shiftop,
  input  logic [DATA_WIDTH-1:0] sh_Result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
`ifdef SHIFT_ISSUE_ILLEGAL_EN
  output logic                  out_illegal,
`endif
  output logic [4:0]            out_waddr
);

  logic          s1_valid;
  logic          s2_valid;
  s1_t           s1_q;
  s2_t           s2_q;
  logic          s1_adv;
  logic          s2_adv;
  logic          accept;
  logic          keep;
  logic [1:0]    dec_op;
  logic [AW-1:0] dec_amount;
  logic [AW-1:0] dec_waddr;
  logic          dec_illegal;

  shift_decode u_decode (
    .inst    (in_inst),
    .rs_data (in_rs_data),
    .op      (dec_op),
    .amount  (dec_amount),
    .waddr   (dec_waddr),
    .illegal (dec_illegal)
  );

  // A stage may load when it is empty or its current content is leaving
  assign s2_adv   = !s2_valid | out_ready;
  assign s1_adv   = !s1_valid | s2_adv;
  assign in_ready = s1_adv & !flush;
  assign accept   = in_valid & in_ready;

`ifdef SHIFT_ISSUE_ILLEGAL_EN
  assign keep = 1'b1;
`else
  // Non-shift instructions complete the handshake but never occupy S1
  assign keep = !dec_illegal;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= accept & keep;
      end
      if (accept) begin
        s1_q.a       <= in_rt_data;
        s1_q.b       <= dec_amount;
        s1_q.op      <= dec_op;
        s1_q.waddr   <= dec_waddr;
        s1_q.illegal <= dec_illegal;
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
      end
      // S2 data only changes when a real S1 entry moves in, keeping out_* stable otherwise
      if (s2_adv && s1_valid) begin
        s2_q.result  <= s1_q.illegal ? '0 : sh_Result;
        s2_q.waddr   <= s1_q.waddr;
        s2_q.illegal <= s1_q.illegal;
      end
    end
  end

  assign sh_A       = s1_q.a;
  assign sh_B       = s1_q.b;
  assign sh_Shiftop = s1_q.op;

  assign out_valid  = s2_valid;
  assign out_result = s2_q.result;
  assign out_waddr  = s2_q.waddr;

`ifdef SHIFT_ISSUE_ILLEGAL_EN
  assign out_illegal = s2_q.illegal;
`else
  logic unused_s2_illegal;
  assign unused_s2_illegal = s2_q.illegal;
`endif

endmodule

// File: tb/tb_shift_issue.sv
module tb_shift_issue;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_rs_data;
  logic [31:0] in_rt_data;
  logic [31:0] sh_A;
  logic [4:0]  sh_B;
  logic [1:0]  sh_Shiftop;
  logic [31:0] sh_Result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_waddr;
`ifdef SHIFT_ISSUE_ILLEGAL_EN
  logic        out_illegal;
`endif

  int errors = 0;
  int checks = 0;

  shift_issue #(.DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_inst    (in_inst),
    .in_rs_data (in_rs_data),
    .in_rt_data (in_rt_data),
    .sh_A       (sh_A),
    .sh_B       (sh_B),
    .sh_Shiftop (sh_Shiftop),
    .sh_Result  (sh_Result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
`ifdef SHIFT_ISSUE_ILLEGAL_EN
    .out_illegal(out_illegal),
`endif
    .out_waddr  (out_waddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stand-in for the external combinational shifter
  always_comb begin
    sh_Result = 32'h0;
    case (sh_Shiftop)
      2'b00:   sh_Result = sh_A << sh_B;
      2'b10:   sh_Result = sh_A >> sh_B;
      2'b11:   sh_Result = $unsigned($signed(sh_A) >>> sh_B);
      default: sh_Result = 32'h0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_inst    = 32'h0;
    in_rs_data = 32'h0;
    in_rt_data = 32'h0;
    out_ready  = 1'b1;
    #2;
    chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
    chk("reset_out_result", out_result, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", {31'h0, in_ready}, 32'h1);
    chk("reset_sh_A", sh_A, 32'h0);
    chk("reset_sh_B", {27'h0, sh_B}, 32'h0);
    chk("reset_sh_op", {30'h0, sh_Shiftop}, 32'h0);
    chk("reset_out_waddr", {27'h0, out_waddr}, 32'h0);

    // SRA $2, $3, 2 with rt = 0x80000010
    in_valid   = 1'b1;
    in_inst    = 32'h00031083;
    in_rt_data = 32'h80000010;
    tick();
    in_valid = 1'b0;
    chk("sra_sh_op", {30'h0, sh_Shiftop}, 32'h3);
    chk("sra_sh_B", {27'h0, sh_B}, 32'h2);
    chk("sra_sh_A", sh_A, 32'h80000010);
    chk("sra_s1_out_valid", {31'h0, out_valid}, 32'h0);
    tick();
    chk("sra_out_valid", {31'h0, out_valid}, 32'h1);
    chk("sra_out_result", out_result, 32'hE0000004);
    chk("sra_out_waddr", {27'h0, out_waddr}, 32'h2);
`ifdef SHIFT_ISSUE_ILLEGAL_EN
    chk("sra_out_illegal", {31'h0, out_illegal}, 32'h0);
`endif

    // SLLV $6, $5, $4 with rs = 0x24 (amount 4), rt = 0xF
    in_valid   = 1'b1;
    in_inst    = 32'h00853004;
    in_rs_data = 32'h00000024;
    in_rt_data = 32'h0000000F;
    tick();
    in_valid = 1'b0;
    chk("sllv_sh_B", {27'h0, sh_B}, 32'h4);
    chk("sllv_sh_op", {30'h0, sh_Shiftop}, 32'h0);
    chk("sllv_drain_out_valid", {31'h0, out_valid}, 32'h0);
    tick();
    chk("sllv_out_valid", {31'h0, out_valid}, 32'h1);
    chk("sllv_out_result", out_result, 32'h000000F0);
    chk("sllv_out_waddr", {27'h0, out_waddr}, 32'h6);
    tick();
    chk("empty_out_valid", {31'h0, out_valid}, 32'h0);

    // Backpressure: three SRL $7, $1, sa on rt = 0x80
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_rs_data = 32'h0;
    in_rt_data = 32'h00000080;
    in_inst    = 32'h00013842;
    #1;
    chk("bp_ready_1", {31'h0, in_ready}, 32'h1);
    tick();
    in_inst = 32'h00013882;
    #1;
    chk("bp_ready_2", {31'h0, in_ready}, 32'h1);
    tick();
    in_inst = 32'h000138C2;
    #1;
    chk("bp_ready_full", {31'h0, in_ready}, 32'h0);
    chk("bp_out_valid", {31'h0, out_valid}, 32'h1);
    chk("bp_out_first", out_result, 32'h00000040);
    tick();
    chk("bp_hold_ready", {31'h0, in_ready}, 32'h0);
    chk("bp_hold_result", out_result, 32'h00000040);
    chk("bp_hold_waddr", {27'h0, out_waddr}, 32'h7);
    out_ready = 1'b1;
    #1;
    chk("bp_drain_ready", {31'h0, in_ready}, 32'h1);
    tick();
    in_valid = 1'b0;
    chk("bp_out_second", out_result, 32'h00000020);
    chk("bp_out_second_vld", {31'h0, out_valid}, 32'h1);
    tick();
    chk("bp_out_third", out_result, 32'h00000010);
    chk("bp_out_third_vld", {31'h0, out_valid}, 32'h1);
    tick();
    chk("bp_empty", {31'h0, out_valid}, 32'h0);

    // Flush with both stages full and a new instruction offered
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_rt_data = 32'h00000001;
    in_inst    = 32'h00013842;
    tick();
    tick();
    #1;
    chk("flush_pre_valid", {31'h0, out_valid}, 32'h1);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", {31'h0, in_ready}, 32'h0);
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("flush_out_valid", {31'h0, out_valid}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("flush_no_emerge", {31'h0, out_valid}, 32'h0);
    end

    // Non-shift instruction (ADD)
    in_valid   = 1'b1;
    in_inst    = 32'h00851020;
    in_rt_data = 32'h12345678;
    #1;
    chk("illegal_in_ready", {31'h0, in_ready}, 32'h1);
    tick();
    in_valid = 1'b0;
    tick();
`ifdef SHIFT_ISSUE_ILLEGAL_EN
    chk("illegal_out_valid", {31'h0, out_valid}, 32'h1);
    chk("illegal_flag", {31'h0, out_illegal}, 32'h1);
    chk("illegal_result", out_result, 32'h0);
`else
    chk("illegal_dropped", {31'h0, out_valid}, 32'h0);
    tick();
    chk("illegal_dropped_2", {31'h0, out_valid}, 32'h0);
`endif
    tick();

    // Asynchronous reset with S2 holding a result under backpressure
    out_ready  = 1'b0;
    in_valid   = 1'b1;
    in_inst    = 32'h00031083;
    in_rt_data = 32'h80000010;
    tick();
    in_valid = 1'b0;
    tick();
    chk("rst_pre_valid", {31'h0, out_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_result", out_result, 32'h0);
    chk("rst_out_waddr", {27'h0, out_waddr}, 32'h0);
    chk("rst_sh_A", sh_A, 32'h0);
    chk("rst_sh_B", {27'h0, sh_B}, 32'h0);
    chk("rst_sh_op", {30'h0, sh_Shiftop}, 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst_release_ready", {31'h0, in_ready}, 32'h1);
    tick();
    chk("rst_release_valid", {31'h0, out_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shift_issue.md
# shift_issue

Two-stage pipelined issue unit for MIPS R-type shift instructions (SLL, SRL, SRA, SLLV, SRLV, SRAV), sitting directly upstream of the combinational `shifter` in the EX stage. It decodes the instruction, selects the shift amount, drives the shifter's `A`/`B`/`Shiftop` from registered operands, and captures `Result` into an output register with the writeback address. Valid/ready handshakes on both sides carry backpressure from writeback up to decode.

## Interface
- `DATA_WIDTH`, 32, operand/result width; only 32 is supported.
- `clk` input 1: the single clock.
- `rst_n` input 1: reset. One clock; reset is asynchronous and active-low.
- `flush` input 1: synchronous pipeline kill.
- `in_valid` input 1: upstream offers an instruction.
- `in_ready` output 1: the unit accepts this cycle.
- `in_inst` input 32: the instruction word.
- `in_rs_data` input 32: GPR[rs].
- `in_rt_data` input 32: GPR[rt].
- `sh_A` output 32: shifter operand; equals the stage-1 rt value.
- `sh_B` output 5: shifter amount.
- `sh_Shiftop` output 2: 00 = left, 10 = logical right, 11 = arithmetic right.
- `sh_Result` input 32: shifter output, same cycle.
- `out_valid` output 1: a result is available.
- `out_ready` input 1: downstream accepts.
- `out_result` output 32: the shift result.
- `out_waddr` output 5: destination register, `inst[15:11]`.
- `out_illegal` output 1: present only with `SHIFT_ISSUE_ILLEGAL_EN`.

## Operation
- Decode applies when `inst[31:26]==0`. The funct field selects the operation:
  - 000000 SLL, 000010 SRL, 000011 SRA: amount is `inst[10:6]`.
  - 000100 SLLV, 000110 SRLV, 000111 SRAV: amount is `in_rs_data[4:0]`.
- Shiftop by operation: SLL/SLLV 00, SRL/SRLV 10, SRA/SRAV 11.
- Any other encoding is non-shift. Handling is defined under Configuration.
- Stage 1 (S1) register holds `valid`, A, B, op, waddr and illegal. Its outputs drive `sh_*` directly.
- Stage 2 (S2) register holds `valid`, `sh_Result` (0 if illegal), waddr and illegal. Its outputs drive `out_*`.
- Handshake rules:
  - `s2_adv = !s2_valid | out_ready`.
  - `s1_adv = !s1_valid | s2_adv`.
  - `in_ready = s1_adv & !flush`.
  - Transfer occurs when valid and ready are both high at the rising edge.
  - Once `out_valid` is asserted, `out_*` holds stable until `out_ready`.
- `flush=1` clears `s1_valid` and `s2_valid` at the next edge. It overrides any simultaneous acceptance and advance, and the data registers are don't-care.
- Reset, asynchronous at any time including mid-transfer: all valid bits go to 0 and all data registers to 0.
  - `in_ready` reads 1 while reset is released and `flush=0`.
  - `sh_*`, `out_result` and `out_waddr` read 0.
- `sh_*` may toggle while S1 is invalid; the shifter is combinational and has no side effects.

## Timing
- Latency: input accepted at edge N makes `out_valid` high after edge N+1, provided S2 is free.
- Throughput: one instruction per cycle while `out_ready=1`.
- Full condition: both stages valid and `out_ready=0`, so `in_ready=0`. Two instructions are buffered.
- Drain: with the pipeline full and `out_ready` raised, S2 drains and S1 moves to S2 at the same edge. `in_ready` is high in that same cycle (combinational chain).
- Order is strictly preserved. There is no bypass from input to output.

## Configuration
- `SHIFT_ISSUE_ILLEGAL_EN` defined:
  - Non-shift instructions are accepted and flow through the pipeline.
  - They emerge with `out_illegal=1` and `out_result=0`.
  - `out_illegal` is 0 for legal instructions.
- Undefined:
  - Non-shift instructions are accepted (handshake completes) and discarded; S1 `valid` is not set.
  - The `out_illegal` port does not exist.

## Structure
- The shared package holds:
  - `SHIFTOP_LEFT`/`SHIFTOP_RIGHT_LOG`/`SHIFTOP_RIGHT_ART` (00/10/11).
  - The six funct constants.
  - `OPCODE_SPECIAL`.
  - The S1/S2 payload struct typedefs.
- One natural sub-module, `shift_decode`: combinational mapping from inst and rs_data to op, amount, waddr and illegal.
- The `shifter` itself stays external to this block; it is instantiated beside it in EX.

## Test plan
- **SRA:** `in_inst=0x00031083`, `rt_data=0x80000010`. Required: `sh_Shiftop=11`, `sh_B=2`; two edges later `out_valid=1`, `out_result=0xE0000004`, `out_waddr=2`.
- **SLLV:** `in_inst=0x00853004`, `rs_data=0x00000024`, `rt_data=0x0000000F`. Required: `sh_B=4`, `out_result=0x000000F0`, `out_waddr=6`.
- **Backpressure:** `out_ready=0`, three back-to-back SRL instructions with sa=1,2,3 on `rt_data=0x80`. Required: `in_ready` drops after the second accept. After `out_ready=1`, the outputs are 0x40, 0x20, 0x10 in order on consecutive cycles.
- **Flush:** `flush=1` with both stages full and `in_valid=1`. Required: `in_ready=0` that cycle; the next cycle `out_valid=0` and `sh_*` are unused; no result ever emerges.
- **Illegal:** `in_inst=0x00851020` (ADD). With the macro: `out_illegal=1`, `out_result=0`. Without: the input is accepted and `out_valid` stays 0.
- **Reset mid-operation:** pull `rst_n` low with S2 valid and `out_ready=0`. Required: `out_valid=0` immediately (asynchronous), and all outputs 0.
